spi_reg_ctrl: RTL and testbench
===============================

Name:
spi_reg_ctrl

Overview:
- Register-access controller that sequences the clockless SPI slave datapath.
- Decodes the command byte, captures an address byte, then streams data bytes.
  - Write frames: data bytes go into the register file.
  - Read frames: data bytes come out of the register file, with address auto-increment.
- Sits between the SPI slave shifter (slave_in, MISO serializer) and the register file.
- Runs entirely on dat_rcv_clk (SCLK gated by ~CSn), so it has no free-running clock.

Parameters:
- ADDR_W, 8, register address width.
- WR_OP, 8'h3C, write command code.
- RD_OP, 8'h5B, read command code.

Ports:
- dat_rcv_clk  input  1  clock: SCLK & ~CSn; rising edges occur only inside a frame.
- sclk_rstn  input  1  reset: asynchronous, active-low.
- CSn  input  1  chip select, active-low; high = frame boundary.
- slave_in  input  8  shift register from SPI slave; pre-edge value holds the last 8 bits received.
- reg_addr  output  ADDR_W  current register address; shared by read and write.
- reg_we  output  1  combinational write strobe; register file writes on the same dat_rcv_clk rising edge.
- reg_wdata  output  8  write data (= slave_in).
- reg_rdata  input  8  combinational register-file read data at reg_addr.
- slave_out_dat  output  8  byte to serialize on MISO (= reg_rdata in read frames, 8'hFF otherwise).
- op_err  output  1  last frame carried an unknown command.

Behaviour:
- Frame-relative view:
  - bit_cnt (3b, wraps) and byte_idx (2b, saturates at 3) count dat_rcv_clk edges within the frame.
  - The effective values are forced to 0 while CSn=1, so the first edge of every frame sees bit_cnt=0, byte_idx=0, state=CMD, regardless of stored values.
  - Each edge increments bit_cnt; on wrap 7->0, byte_idx increments (saturating at 3).
- A byte completes at an edge where effective bit_cnt==0 and byte_idx>=1; the pre-edge slave_in is that byte.
- States: CMD, ADDR, WR, RD, IGN.
  - CMD: at the first byte completion (edge 8):
    - slave_in==WR_OP -> ADDR, mode=write.
    - slave_in==RD_OP -> ADDR, mode=read.
    - otherwise -> IGN and op_err<=1.
    - On WR_OP/RD_OP, op_err<=0.
  - ADDR: at edge 16, reg_addr<=slave_in[ADDR_W-1:0] (zero-extended if ADDR_W>8); go to WR or RD.
  - WR: at each byte completion (edge 24, 32, ...):
    - reg_we=1 for that edge only; reg_wdata=slave_in; reg_addr holds the target address.
    - Same edge: reg_addr<=reg_addr+1.
  - RD:
    - slave_out_dat=reg_rdata from edge 16 onward, so MISO bit7 is valid before edge 17.
    - At each byte completion, reg_addr<=reg_addr+1; the next byte reflects the new address before the following edge.
  - IGN: no writes; slave_out_dat=8'hFF until the frame ends.
- Address increment wraps modulo 2^ADDR_W (e.g. 8'hFF -> 8'h00).
- Combinational conditions:
  - reg_we=0 whenever CSn=1 or the state is not WR.
  - slave_out_dat=8'hFF in every state except RD.
- CSn rising mid-byte:
  - The partial byte is discarded: no write, no increment.
  - State is frozen (no clock); the next frame restarts at CMD via the CSn-gated view.
- Reset values: reg_addr=0, reg_we=0, slave_out_dat=8'hFF, op_err=0, state=CMD, bit_cnt=0, byte_idx=0.
- Reset asserted mid-frame clears all state immediately; the next edge is treated as frame bit 0.

Optional Feature:
- Macro: SPI_REG_CTRL_AUTOINC_EN.
  - Defined: address auto-increments after each data byte, as above.
  - Undefined: reg_addr holds the captured address for the whole frame; repeated writes hit the same register and repeated reads return the same register.

Test Plan:
- Write frame 3C,10,A5,5A then CSn high -> reg_we pulses at edges 24 and 32; writes A5@0x10 and 5A@0x11; op_err=0.
- Read frame 5B,20, regs[20]=C3, regs[21]=7E -> MISO shifts C3 then 7E; reg_addr=0x22 at frame end.
- Write 3C,FF,11,22 -> writes 11@0xFF and 22@0x00 (wrap).
- Frame 99,10,AA -> no reg_we; MISO all 1s; op_err=1. A following valid 3C frame clears op_err.
- Write 3C,10 + 5 bits, CSn high, then new frame 3C,30,44 -> no write to 0x10; 44@0x30; controller restarted cleanly.
- Without SPI_REG_CTRL_AUTOINC_EN: 3C,40,01,02 -> both writes to 0x40, final value 02.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command/address/data sequencer between the clockless SPI slave and a register file.
// Optional macro SPI_REG_CTRL_AUTOINC_EN enables address auto-increment after each data byte.
module spi_reg_ctrl #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] WR_OP  = 8'h3C,
    parameter logic [7:0] RD_OP  = 8'h5B
) (
    input  logic              dat_rcv_clk,
    input  logic              sclk_rstn,
    input  logic              CSn,
    input  logic [7:0]        slave_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_we,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic [7:0]        slave_out_dat,
    output logic              op_err
);
    typedef enum logic [2:0] {CMD, ADDR, WR, RD, IGN} state_t;
`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] ADDR_INC = '0;
`endif
    state_t     state;
    logic       rd_mode;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic       frame_rstn;
    logic       byte_done;
    // There is no clock between frames, so CSn high clears the frame-relative view asynchronously.
    assign frame_rstn = sclk_rstn & ~CSn;
    assign byte_done  = bit_cnt == 3'd0 && byte_idx != 2'd0;
    assign reg_we        = !CSn && state == WR && byte_done;
    assign reg_wdata     = slave_in;
    assign slave_out_dat = (!CSn && state == RD) ? reg_rdata : 8'hFF;
    always_ff @(posedge dat_rcv_clk or negedge frame_rstn) begin
        if (!frame_rstn) begin
            state    <= CMD;
            rd_mode  <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && byte_idx != 2'd3)
                byte_idx <= byte_idx + 2'd1;
            if (byte_done)
                case (state)
                    CMD: begin
                        state   <= (slave_in == WR_OP || slave_in == RD_OP) ? ADDR : IGN;
                        rd_mode <= slave_in == RD_OP;
                    end
                    ADDR:    state <= rd_mode ? RD : WR;
                    default: ;
                endcase
        end
    end
    // Address and error flag persist across frames, so only the real reset clears them.
    always_ff @(posedge dat_rcv_clk or negedge sclk_rstn) begin
        if (!sclk_rstn) begin
            reg_addr <= '0;
            op_err   <= 1'b0;
        end else if (byte_done)
            case (state)
                CMD:     op_err   <= !(slave_in == WR_OP || slave_in == RD_OP);
                ADDR:    reg_addr <= ADDR_W'(slave_in);
                WR, RD:  reg_addr <= reg_addr + ADDR_INC;
                default: ;
            endcase
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: frame-level model of the register controller checked every SCLK cycle.
module tb_spi_reg_ctrl;
`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic       sclk = 1'b0;
    logic       dat_rcv_clk;
    logic       sclk_rstn;
    logic       CSn;
    logic [7:0] slave_in;
    logic [7:0] reg_addr;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] slave_out_dat;
    logic       op_err;
    logic [7:0] rf [256];
    logic [7:0] m_regs [256];
    logic [7:0] m_addr;
    logic       m_err;
    logic       exp_we, exp_err;
    logic [7:0] exp_out, exp_addr;
    logic [7:0] miso [$];
    logic       chk = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 sclk = ~sclk;
    assign dat_rcv_clk = sclk & ~CSn;
    assign reg_rdata   = rf[reg_addr];

    always @(posedge dat_rcv_clk) if (reg_we) rf[reg_addr] <= reg_wdata;

    spi_reg_ctrl dut (
        .dat_rcv_clk(dat_rcv_clk), .sclk_rstn(sclk_rstn), .CSn(CSn), .slave_in(slave_in),
        .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .slave_out_dat(slave_out_dat), .op_err(op_err)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sclk) if (chk) begin
        #2;
        check("reg_we", {7'd0, reg_we}, {7'd0, exp_we});
        check("slave_out_dat", slave_out_dat, exp_out);
        check("reg_addr", reg_addr, exp_addr);
        check("op_err", {7'd0, op_err}, {7'd0, exp_err});
    end

    // Drives nbytes*8+extra SCLK edges of a frame; model updates follow each edge.
    task automatic frame(input logic [31:0] data, input int nbytes, input int extra);
        logic [7:0] b [4];
        logic wr, rd;
        int nb;
        nb = nbytes * 8 + extra;
        for (int j = 0; j < 4; j++) b[j] = data[31-8*j -: 8];
        wr = b[0] == 8'h3C;
        rd = b[0] == 8'h5B;
        miso.delete();
        for (int n = 0; n < nb; n++) begin
            @(negedge sclk);
            CSn      = 1'b0;
            exp_we   = wr && n >= 24 && n % 8 == 0;
            exp_out  = (rd && n >= 17) ? m_regs[m_addr] : 8'hFF;
            exp_addr = m_addr;
            exp_err  = m_err;
            @(posedge sclk);
            #1;
            slave_in = {slave_in[6:0], (n < nbytes * 8) ? b[n/8][7-n%8] : 1'b0};
            if (n % 8 == 0 && n >= 8) begin
                if (n == 8) m_err = !(wr || rd);
                else if (n == 16 && (wr || rd)) m_addr = b[1];
                else if (wr || rd) begin
                    if (wr) m_regs[m_addr] = b[n/8-1];
                    m_addr = m_addr + 8'(AUTO);
                end
                if (rd && n >= 16) miso.push_back(slave_out_dat);
            end
        end
        @(negedge sclk);
        CSn      = 1'b1;
        exp_we   = 1'b0;
        exp_out  = 8'hFF;
        exp_addr = m_addr;
        exp_err  = m_err;
        repeat (2) @(negedge sclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rf[i]     = 8'h00;
            m_regs[i] = 8'h00;
        end
        CSn       = 1'b1;
        sclk_rstn = 1'b0;
        slave_in  = 8'h00;
        m_addr    = 8'h00;
        m_err     = 1'b0;
        exp_we    = 1'b0;
        exp_out   = 8'hFF;
        exp_addr  = 8'h00;
        exp_err   = 1'b0;
        repeat (2) @(negedge sclk);
        #1;
        check("rst reg_addr", reg_addr, 8'h00);
        check("rst reg_we", {7'd0, reg_we}, 8'h00);
        check("rst slave_out_dat", slave_out_dat, 8'hFF);
        check("rst op_err", {7'd0, op_err}, 8'h00);
        sclk_rstn = 1'b1;
        chk = 1'b1;

        frame(32'h3C10A55A, 4, 1);
        check("wr rf[10]", rf[8'h10], AUTO ? 8'hA5 : 8'h5A);
        check("wr rf[11]", rf[8'h11], AUTO ? 8'h5A : 8'h00);
        check("wr op_err", {7'd0, op_err}, 8'h00);

        rf[8'h20] = 8'hC3; m_regs[8'h20] = 8'hC3;
        rf[8'h21] = 8'h7E; m_regs[8'h21] = 8'h7E;
        frame(32'h5B200000, 4, 1);
        check("rd miso count", 8'(miso.size()), 8'd3);
        if (miso.size() >= 2) begin
            check("rd miso byte0", miso[0], 8'hC3);
            check("rd miso byte1", miso[1], AUTO ? 8'h7E : 8'hC3);
        end
        check("rd end addr", reg_addr, AUTO ? 8'h22 : 8'h20);

        frame(32'h3CFF1122, 4, 1);
        check("wrap rf[FF]", rf[8'hFF], AUTO ? 8'h11 : 8'h22);
        check("wrap rf[00]", rf[8'h00], AUTO ? 8'h22 : 8'h00);

        frame(32'h9910AA00, 3, 1);
        check("bad op_err", {7'd0, op_err}, 8'h01);

        frame(32'h3C100000, 2, 5);
        check("partial op_err", {7'd0, op_err}, 8'h00);
        check("partial rf[10]", rf[8'h10], AUTO ? 8'hA5 : 8'h5A);
        check("partial addr", reg_addr, 8'h10);
        frame(32'h3C304400, 3, 1);
        check("restart rf[30]", rf[8'h30], 8'h44);
        check("restart rf[10]", rf[8'h10], AUTO ? 8'hA5 : 8'h5A);

        frame(32'h3C400102, 4, 1);
        check("same rf[40]", rf[8'h40], AUTO ? 8'h01 : 8'h02);
        check("same rf[41]", rf[8'h41], AUTO ? 8'h02 : 8'h00);

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
